fifo_push_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one fifo_flops instance among N_REQ producers.
//  - Grants one producer at a time, for a burst of up to MAX_BURST words.
//  - Muxes the owner's data onto the FIFO Din/push pins and back-pressures everyone else.
//  - Honours the FIFO full flag.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/fifo_push_arbiter_if.sv | 24 ++
 rtl/fifo_push_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_push_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_MAX_BURST = 4;

  function automatic int calc_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must be able to hold MAX_BURST itself, hence the +1.
  function automatic int calc_cnt_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

  localparam int DEFAULT_PTR_W = calc_ptr_w(DEFAULT_N_REQ);
  localparam int DEFAULT_CNT_W = calc_cnt_w(DEFAULT_MAX_BURST);

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side request bus plus FIFO write-port signals of the push arbiter.
interface fifo_push_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       fifo_din;
  logic                   fifo_push;
  logic                   fifo_full;
  logic [N_REQ-1:0]       grant_oh;
  logic                   busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_din, fifo_push, grant_oh, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_din, fifo_push, grant_oh, busy
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Rotating priority encoder: first valid, non-excluded requester scanning from start_ptr_i.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = calc_ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [PTR_W-1:0] start_ptr_i,
  input  logic [N_REQ-1:0] exclude_oh_i,
  output logic             found_o,
  output logic [PTR_W-1:0] idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic             hit;
  logic [PTR_W-1:0] cand;

  always_comb begin
    hit      = 1'b0;
    cand     = '0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(start_ptr_i) + k) % N_REQ);
      if (!hit && req_valid_i[cand] && !exclude_oh_i[cand]) begin
        hit            = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin write arbiter sharing one FIFO push port among N_REQ producers,
// granting each owner a burst of up to MAX_BURST words.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input logic                clk_i,
  input logic                rst_ni,
  fifo_push_arbiter_if.slave bus
);

  localparam int               PTR_W    = calc_ptr_w(N_REQ);
  localparam int               CNT_W    = calc_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push;
  logic             ownerValid;
  logic             releaseGrant;
  logic [PTR_W-1:0] scanStart;
  logic [N_REQ-1:0] scanExclude;
  logic             pickFound;
  logic [PTR_W-1:0] pickIdx;
  logic [N_REQ-1:0] pickOh;

  // While bursting, the scan starts just past the owner and skips it, so a
  // release can hand over to the next requester on the same edge.
  always_comb begin
    push         = (|(grant_q & bus.req_valid)) & ~bus.fifo_full;
    ownerValid   = bus.req_valid[owner_q];
    scanStart    = (state_q == BURST) ? PTR_W'(rr_next(int'(owner_q), N_REQ)) : ptr_q;
    scanExclude  = (state_q == BURST) ? grant_q : '0;
    releaseGrant = (state_q == BURST) && (!ownerValid || (push && (cnt_q == LAST_CNT)));
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid_i  (bus.req_valid),
    .start_ptr_i  (scanStart),
    .exclude_oh_i (scanExclude),
    .found_o      (pickFound),
    .idx_o        (pickIdx),
    .onehot_o     (pickOh)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = BURST;
          grant_d = pickOh;
          owner_d = pickIdx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (releaseGrant) begin
          ptr_d = scanStart;
          cnt_d = '0;
          if (pickFound) begin
            grant_d = pickOh;
            owner_d = pickIdx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (push) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything here derives from grant_q, so an async reset silences the port immediately.
  always_comb begin
    bus.req_ready = grant_q & {N_REQ{~bus.fifo_full}};
    bus.fifo_push = push;
    bus.fifo_din  = (grant_q != '0) ? bus.req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
    bus.grant_oh  = grant_q;
    bus.busy      = (state_q == BURST);
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed scoreboard bench: dutA runs MAX_BURST=4, dutB runs MAX_BURST=1 for fairness.
module tb_fifo_push_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam logic [15:0] BASE_A [N] = '{16'h0A00, 16'h1B00, 16'h2C00, 16'h3D00};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter_if #(.N_REQ(N), .WIDTH(W)) aIf ();
  fifo_push_arbiter_if #(.N_REQ(N), .WIDTH(W)) bIf ();

  fifo_push_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dutA (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (aIf)
  );

  fifo_push_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(1)) dutB (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bIf)
  );

  logic [15:0] expA [$];
  logic [15:0] expB [$];

  // Producer model for dutA: each requester emits BASE+k, advancing on every
  // accepted word and restarting at 0 once it has gone idle.
  logic [7:0]   idxA [N] = '{default: 8'h00};
  logic [N-1:0] accA  = '0;
  logic [N-1:0] seenA = '0;

  always @(negedge clk) begin
    accA  <= aIf.req_valid & aIf.req_ready;
    seenA <= aIf.req_valid;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (!seenA[i])     idxA[i] <= 8'h00;
        else if (accA[i])  idxA[i] <= idxA[i] + 8'h01;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      aIf.req_data[i*W +: W] = BASE_A[i] + {8'h00, idxA[i]};
      bIf.req_data[i*W +: W] = 16'hB000 | (16'(i) << 4);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] vA, input logic [N-1:0] vB, input logic fullA);
    aIf.req_valid = vA;
    bIf.req_valid = vB;
    aIf.fifo_full = fullA;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNeg();
    @(negedge clk);
  endtask

  // Scoreboard monitors: every word the DUT pushes must match the head of the queue.
  always @(negedge clk) begin
    checkOutput("A no push while full", {31'b0, aIf.fifo_push & aIf.fifo_full}, 32'd0);
    if (aIf.fifo_push) begin
      if (expA.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL A unexpected push: got %h, expected no push at %0t", aIf.fifo_din, $time);
      end else begin
        checkOutput("A pushed word", {16'h0, aIf.fifo_din}, {16'h0, expA.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (bIf.fifo_push) begin
      if (expB.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL B unexpected push: got %h, expected no push at %0t", bIf.fifo_din, $time);
      end else begin
        checkOutput("B pushed word", {16'h0, bIf.fifo_din}, {16'h0, expB.pop_front()});
      end
    end
  end

  initial begin
    bIf.fifo_full = 1'b0;
    applyStimulus(4'hF, 4'hF, 1'b0);

    // Reset with everyone requesting: nothing granted or pushed.
    #1;
    checkOutput("reset A grant", aIf.grant_oh, 0);
    checkOutput("reset A push", aIf.fifo_push, 0);
    checkOutput("reset A din", aIf.fifo_din, 0);
    checkOutput("reset A ready", aIf.req_ready, 0);
    checkOutput("reset A busy", aIf.busy, 0);
    checkOutput("reset B grant", bIf.grant_oh, 0);
    checkOutput("reset B push", bIf.fifo_push, 0);
    expA.push_back(16'h0A00);
    expB.push_back(16'hB000);
    tick();
    tick();
    checkOutput("reset held A grant", aIf.grant_oh, 0);
    rst_n = 1'b1;
    sampleNeg();
    checkOutput("post-release pre-edge A grant", aIf.grant_oh, 0);
    tick();
    sampleNeg();
    checkOutput("first edge A grant", aIf.grant_oh, 4'b0001);
    checkOutput("first edge A busy", aIf.busy, 1);
    checkOutput("first edge B grant", bIf.grant_oh, 4'b0001);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    tick();
    sampleNeg();
    checkOutput("reset test A idle", aIf.grant_oh, 0);
    checkOutput("reset test B idle", bIf.grant_oh, 0);
    checkOutput("reset test A drained", expA.size(), 0);
    checkOutput("reset test B drained", expB.size(), 0);

    // Burst: req0 alone pushes 4 words, bubble, then gets the grant back.
    tick();
    applyStimulus(4'b0001, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) expA.push_back(16'h0A00 + 16'(k));
    sampleNeg();
    checkOutput("burst idle before grant", aIf.grant_oh, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      sampleNeg();
      checkOutput("burst grant req0", aIf.grant_oh, 4'b0001);
    end
    tick();
    sampleNeg();
    checkOutput("burst release bubble grant", aIf.grant_oh, 0);
    checkOutput("burst release bubble push", aIf.fifo_push, 0);
    tick();
    sampleNeg();
    checkOutput("burst re-grant req0", aIf.grant_oh, 4'b0001);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    tick();
    sampleNeg();
    checkOutput("burst end idle", aIf.grant_oh, 0);
    checkOutput("burst drained", expA.size(), 0);

    // Full: req1 stalls three cycles after its second word, then finishes the burst.
    tick();
    applyStimulus(4'b0010, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) expA.push_back(16'h1B00 + 16'(k));
    tick();
    sampleNeg();
    checkOutput("full test grant req1", aIf.grant_oh, 4'b0010);
    tick();
    tick();
    applyStimulus(4'b0010, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      sampleNeg();
      checkOutput("full hold owner", aIf.grant_oh, 4'b0010);
      checkOutput("full no push", aIf.fifo_push, 0);
      checkOutput("full no ready", aIf.req_ready, 0);
    end
    tick();
    applyStimulus(4'b0010, 4'h0, 1'b0);
    sampleNeg();
    checkOutput("full resumed push", aIf.fifo_push, 1);
    tick();
    sampleNeg();
    checkOutput("full last word owner", aIf.grant_oh, 4'b0010);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    checkOutput("full released", aIf.grant_oh, 0);
    checkOutput("full drained", expA.size(), 0);

    // Early drop: req2 leaves after one word, req3 takes over on the next edge.
    tick();
    applyStimulus(4'b1100, 4'h0, 1'b0);
    expA.push_back(16'h2C00);
    expA.push_back(16'h3D00);
    tick();
    sampleNeg();
    checkOutput("drop grant req2", aIf.grant_oh, 4'b0100);
    tick();
    applyStimulus(4'b1000, 4'h0, 1'b0);
    sampleNeg();
    checkOutput("drop owner invalid grant", aIf.grant_oh, 4'b0100);
    checkOutput("drop owner invalid push", aIf.fifo_push, 0);
    tick();
    sampleNeg();
    checkOutput("drop handover req3", aIf.grant_oh, 4'b1000);
    checkOutput("drop rr_ptr", dutA.ptr_q, 3);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    tick();
    sampleNeg();
    checkOutput("drop end idle", aIf.grant_oh, 0);
    checkOutput("drop drained", expA.size(), 0);

    // Async reset mid-burst: push falls without a clock, arbitration restarts at req0.
    tick();
    applyStimulus(4'b0011, 4'h0, 1'b0);
    expA.push_back(16'h0A00);
    expA.push_back(16'h0A01);
    tick();
    sampleNeg();
    checkOutput("areset grant req0", aIf.grant_oh, 4'b0001);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset push falls", aIf.fifo_push, 0);
    checkOutput("areset grant falls", aIf.grant_oh, 0);
    checkOutput("areset ready falls", aIf.req_ready, 0);
    checkOutput("areset din zero", aIf.fifo_din, 0);
    checkOutput("areset busy falls", aIf.busy, 0);
    tick();
    rst_n = 1'b1;
    sampleNeg();
    checkOutput("areset released idle", aIf.grant_oh, 0);
    tick();
    sampleNeg();
    checkOutput("areset restart req0", aIf.grant_oh, 4'b0001);
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    tick();
    sampleNeg();
    checkOutput("areset end idle", aIf.grant_oh, 0);
    checkOutput("areset drained", expA.size(), 0);

    // Fairness on dutB: per-word round-robin, one push every cycle.
    tick();
    applyStimulus(4'h0, 4'hF, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expB.push_back(16'hB000 | (16'(i) << 4));
    for (int k = 0; k < 8; k++) begin
      tick();
      sampleNeg();
      checkOutput("fair grant order", bIf.grant_oh, 4'b0001 << (k % 4));
      checkOutput("fair push every cycle", bIf.fifo_push, 1);
    end
    tick();
    applyStimulus(4'h0, 4'h0, 1'b0);
    sampleNeg();
    tick();
    sampleNeg();
    checkOutput("fair end idle", bIf.grant_oh, 0);
    checkOutput("fair drained", expB.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
